seg7_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment display controller that drives NUM_DIGITS common-select digits from a packed hex word, one digit per scan slot.
It extends the basic hex scanner with a load strobe, per-digit decimal point, blanking and blink, leading-zero suppression, PWM brightness and configurable output polarity.
It sits between the CPU/debug register file and the board's seg/sel pins.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_hex_decode.sv | 17 +
 rtl/seg7_scan_ctrl.sv | 103 ++++++++++
 tb/tb_seg7_scan_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment table, bit positions and elaboration helpers for the 7-segment scanner
//   HEX_SEG : active-high g..a pattern per hex nibble
//   SEG_DP  : bit index of the decimal point in the 8-bit segment word
//   clog2/max : constant-width helpers used for parameter-derived widths
package seg7_pkg;
  localparam int SEG_DP = 7;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble plus decimal point to active-high 8-bit segment pattern
//   i_nib : hex digit value
//   i_dp  : decimal point on
//   o_pat : {dp, g..a}, 1 = segment lit
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  output logic [7:0] o_pat
);
  always_comb begin
    o_pat         = '0;
    o_pat[6:0]    = HEX_SEG[i_nib];
    o_pat[SEG_DP] = i_dp;
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with load, dp, blank, blink, leading-zero suppression and PWM
//   clk, reset          : clock, asynchronous active-high reset
//   i_data/i_dp/i_blank/i_blink : per-digit content, latched when i_load=1
//   i_lz_en, i_bright   : live leading-zero enable and brightness 0..15
//   o_seg, o_sel        : registered segment and digit-select outputs, polarity per parameters
//   o_frame             : one-cycle pulse after the scan wraps to digit 0
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 10000,
  parameter int BLINK_DIV      = 25,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic                    i_load,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  input  logic [NUM_DIGITS-1:0]   i_blink,
  input  logic                    i_lz_en,
  input  logic [3:0]              i_bright,
  output logic [7:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_sel,
  output logic                    o_frame
);
  localparam int AW = max(1, clog2(NUM_DIGITS));
  localparam int CW = clog2(SCAN_DIV);
  localparam int FW = max(1, clog2(BLINK_DIV));
  // XOR with the "off" word applies polarity: all-ones inverts for active-low
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  logic [CW-1:0]           r_cnt;
  logic [AW-1:0]           r_addr;
  logic [FW-1:0]           r_frame_cnt;
  logic                    r_blink_ph;
  logic [4*NUM_DIGITS-1:0] r_data;
  logic [NUM_DIGITS-1:0]   r_dp, r_blank, r_blink, r_sel;
  logic [7:0]              r_seg;
  logic                    r_frame;
  logic                    w_tick, w_wrap, w_flast, w_upper_zero, w_vis, w_gate;
  logic [31:0]             w_lim;
  logic [3:0]              w_nib;
  logic [7:0]              w_pat, w_seg;
  logic [NUM_DIGITS-1:0]   w_sel;
  assign w_tick  = r_cnt == CW'(SCAN_DIV - 1);
  assign w_wrap  = w_tick && (r_addr == AW'(NUM_DIGITS - 1));
  assign w_flast = r_frame_cnt == FW'(BLINK_DIV - 1);
  assign w_nib   = r_data[{r_addr, 2'b00} +: 4];
  seg7_hex_decode u_dec (
    .i_nib (w_nib),
    .i_dp  (r_dp[r_addr]),
    .o_pat (w_pat)
  );
  // current digit and everything above it zero -> candidate for suppression
  always_comb begin
    w_upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (k >= int'(r_addr) && r_data[4*k +: 4] != 4'h0) w_upper_zero = 1'b0;
  end
  assign w_vis  = !r_blank[r_addr] && !(r_blink_ph && r_blink[r_addr]) &&
                  !(i_lz_en && r_addr != '0 && w_upper_zero);
  assign w_lim  = ((32'(i_bright) + 32'd1) * 32'(SCAN_DIV)) >> 4;
  assign w_gate = 32'(r_cnt) < w_lim;
  assign w_sel  = w_gate ? (NUM_DIGITS'(1) << r_addr) : '0;
  assign w_seg  = (w_gate && w_vis) ? w_pat : 8'h00;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_frame_cnt <= '0;
      r_blink_ph  <= 1'b0;
      r_data      <= '0;
      r_dp        <= '0;
      r_blank     <= '0;
      r_blink     <= '0;
      r_frame     <= 1'b0;
      r_sel       <= SEL_OFF;
      r_seg       <= SEG_OFF;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) r_addr <= w_wrap ? '0 : r_addr + AW'(1);
      if (w_wrap) begin
        r_frame_cnt <= w_flast ? '0 : r_frame_cnt + FW'(1);
        if (w_flast) r_blink_ph <= ~r_blink_ph;
      end
      if (i_load) begin
        r_data  <= i_data;
        r_dp    <= i_dp;
        r_blank <= i_blank;
        r_blink <= i_blink;
      end
      r_frame <= w_wrap;
      r_sel   <= w_sel ^ SEL_OFF;
      r_seg   <= w_seg ^ SEG_OFF;
    end
  end
  assign o_seg   = r_seg;
  assign o_sel   = r_sel;
  assign o_frame = r_frame;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed and random checks of seg7_scan_ctrl against a time-indexed reference model
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] i_data = '0;
  logic        i_load = 1'b0;
  logic [3:0]  i_dp = '0, i_blank = '0, i_blink = '0;
  logic        i_lz_en = 1'b0;
  logic [3:0]  i_bright = 4'd15;
  logic [7:0]  o_seg, o_seg2;
  logic [3:0]  o_sel, o_sel2;
  logic        o_frame, o_frame2;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(16), .BLINK_DIV(2), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_load(i_load), .i_dp(i_dp), .i_blank(i_blank),
    .i_blink(i_blink), .i_lz_en(i_lz_en), .i_bright(i_bright), .o_seg(o_seg), .o_sel(o_sel), .o_frame(o_frame));

  seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(16), .BLINK_DIV(2), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .reset(reset), .i_data(i_data), .i_load(i_load), .i_dp(i_dp), .i_blank(i_blank),
    .i_blink(i_blink), .i_lz_en(i_lz_en), .i_bright(i_bright), .o_seg(o_seg2), .o_sel(o_sel2), .o_frame(o_frame2));

  // Reference: n = clocks since reset release. Slot = n/16, digit = slot%4,
  // frame wraps every 64 clocks, blink phase flips every 2 frames (128 clocks).
  logic [7:0]  hex_al [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int          n, m_pos, m_dig, m_ph;
  bit          m_gate, m_vis;
  logic [15:0] m_data;
  logic [3:0]  m_dp, m_blank, m_blink;
  logic [7:0]  e_seg = 8'hFF;
  logic [3:0]  e_sel = 4'hF;
  logic        e_frame = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n = 0; m_data = '0; m_dp = '0; m_blank = '0; m_blink = '0;
      e_seg = 8'hFF; e_sel = 4'hF; e_frame = 1'b0;
    end else begin
      m_pos  = n % 16;
      m_dig  = (n / 16) % 4;
      m_ph   = (n / 128) % 2;
      m_gate = m_pos < (((int'(i_bright) + 1) * 16) >> 4);
      m_vis  = !m_blank[m_dig] && !(m_ph == 1 && m_blink[m_dig]) &&
               !(i_lz_en && m_dig > 0 && (m_data >> (4 * m_dig)) == 16'h0);
      e_sel   = m_gate ? ~(4'b0001 << m_dig) : 4'hF;
      e_seg   = (m_gate && m_vis) ? (hex_al[m_data[4*m_dig +: 4]] & (m_dp[m_dig] ? 8'h7F : 8'hFF)) : 8'hFF;
      e_frame = (n % 64) == 63;
      if (i_load) begin
        m_data = i_data; m_dp = i_dp; m_blank = i_blank; m_blink = i_blink;
      end
      n++;
    end
  end

  task automatic check_all();
    checks++;
    assert (o_sel === e_sel) else begin errors++; $error("FAIL sel obs=%h exp=%h t=%0t", o_sel, e_sel, $time); end
    checks++;
    assert (o_seg === e_seg) else begin errors++; $error("FAIL seg obs=%h exp=%h t=%0t", o_seg, e_seg, $time); end
    checks++;
    assert (o_frame === e_frame) else begin errors++; $error("FAIL frame obs=%b exp=%b t=%0t", o_frame, e_frame, $time); end
    checks++;
    assert (o_sel2 === ~e_sel) else begin errors++; $error("FAIL sel_hi obs=%h exp=%h t=%0t", o_sel2, ~e_sel, $time); end
    checks++;
    assert (o_seg2 === ~e_seg) else begin errors++; $error("FAIL seg_hi obs=%h exp=%h t=%0t", o_seg2, ~e_seg, $time); end
    checks++;
    assert (o_frame2 === e_frame) else begin errors++; $error("FAIL frame_hi obs=%b exp=%b t=%0t", o_frame2, e_frame, $time); end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl, input logic [3:0] bk);
    i_data = d; i_dp = dp; i_blank = bl; i_blink = bk; i_load = 1'b1;
    step(1);
    i_load = 1'b0;
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    step(1);
    checks++;
    assert (o_sel === 4'hE) else begin errors++; $error("FAIL first_sel obs=%h exp=%h", o_sel, 4'hE); end
    step(4);
    load(16'h12AF, 4'h0, 4'h0, 4'h0);
    step(200);
    i_data = 16'h9999; i_dp = 4'hF; i_blank = 4'hF;
    step(80);
    i_lz_en = 1'b1;
    load(16'h0050, 4'h0, 4'h0, 4'h0);
    step(70);
    load(16'h0000, 4'h0, 4'h0, 4'h0);
    step(70);
    i_lz_en = 1'b0;
    load(16'h12AF, 4'h0, 4'h0, 4'h0);
    i_bright = 4'd3;
    step(70);
    i_bright = 4'd15;
    load(16'h1234, 4'h0, 4'b1000, 4'b0001);
    step(300);
    load(16'h0000, 4'b0010, 4'h0, 4'h0);
    step(70);
    for (int i = 0; i < 40; i++) begin
      i_lz_en  = 1'($urandom);
      i_bright = 4'($urandom);
      if ($urandom_range(0, 1) == 1)
        load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0), 4'($urandom));
      else
        i_data = 16'($urandom);
      step($urandom_range(1, 40));
    end
    i_bright = 4'd15;
    step(7);
    #2 reset = 1'b1;
    #1;
    checks++;
    assert (o_sel === 4'hF) else begin errors++; $error("FAIL rst_sel obs=%h exp=%h", o_sel, 4'hF); end
    checks++;
    assert (o_seg === 8'hFF) else begin errors++; $error("FAIL rst_seg obs=%h exp=%h", o_seg, 8'hFF); end
    check_all();
    step(2);
    reset = 1'b0;
    step(1);
    checks++;
    assert (o_sel === 4'hE) else begin errors++; $error("FAIL restart_sel obs=%h exp=%h", o_sel, 4'hE); end
    step(150);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
